// File: rtl/syn_mulberry_bus_arbiter.sv
// Round-robin arbiter sharing the mulberry MUL/DIV bus among P_NUM_REQ requesters, one transaction in flight.
// Latency: request seen in cycle N drives per_sid_o in N+1; result/abort pulses one cycle after the peripheral event.
// Backpressure: issue holds until per_req_rdy_i; a watchdog aborts a wait that exceeds P_TIMEOUT cycles.
module syn_mulberry_bus_arbiter #(
    parameter int P_NUM_REQ = 4,
    parameter int P_DATA_W  = 32,
    parameter int P_SID_W   = 2,
    parameter int P_TIMEOUT = 1023
) (
    input  logic                            clk_ir,
    input  logic                            rst_ir,
    input  logic [P_NUM_REQ*P_SID_W-1:0]    req_sid_i,
    input  logic [P_NUM_REQ*P_DATA_W-1:0]   req_data_i,
    output logic [P_NUM_REQ-1:0]            req_rdy_o,
    output logic [P_NUM_REQ-1:0]            res_valid_o,
    output logic [P_DATA_W-1:0]             res_o,
    output logic [P_SID_W-1:0]              per_sid_o,
    output logic [P_DATA_W-1:0]             per_data_o,
    input  logic                            per_req_rdy_i,
    input  logic                            per_res_valid_i,
    input  logic [P_DATA_W-1:0]             per_res_i,
    output logic                            timeout_err_o,
    output logic [$clog2(P_NUM_REQ)-1:0]    grant_id_o
);
    localparam int ID_W = $clog2(P_NUM_REQ);
    localparam int WD_W = $clog2(P_TIMEOUT + 1);
    localparam logic [P_SID_W-1:0] SID_IDLE = '0;

    typedef enum logic [1:0] {IDLE_S, ISSUE_S, WAIT_RES_S} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [WD_W-1:0]     watchdog;

    logic [P_SID_W-1:0]  sid_arr  [P_NUM_REQ];
    logic [P_DATA_W-1:0] data_arr [P_NUM_REQ];
    logic [P_NUM_REQ-1:0] pending;
    logic [P_NUM_REQ-1:0] grant_mask;
    logic                pick_vld;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     next_ptr;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(P_NUM_REQ)) s = s - 32'(P_NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_unpack
        assign sid_arr[g]  = req_sid_i[g*P_SID_W +: P_SID_W];
        assign data_arr[g] = req_data_i[g*P_DATA_W +: P_DATA_W];
        assign pending[g]  = (sid_arr[g] != SID_IDLE);
    end

    // Scan from the farthest offset down so the nearest pending requester at/after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr, 32'(i));
            if (pending[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_comb begin
        grant_mask             = '0;
        grant_mask[grant_id_o] = 1'b1;
    end

    assign next_ptr = wrap_add(grant_id_o, 32'd1);

    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            state         <= IDLE_S;
            rr_ptr        <= '0;
            watchdog      <= '0;
            grant_id_o    <= '0;
            per_sid_o     <= SID_IDLE;
            per_data_o    <= '0;
            req_rdy_o     <= '0;
            res_valid_o   <= '0;
            res_o         <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            req_rdy_o   <= '0;
            res_valid_o <= '0;
            case (state)
                IDLE_S: begin
                    if (pick_vld) begin
                        grant_id_o <= pick_id;
                        per_sid_o  <= sid_arr[pick_id];
                        per_data_o <= data_arr[pick_id];
                        state      <= ISSUE_S;
                    end
                end
                ISSUE_S: begin
                    if (per_req_rdy_i) begin
                        per_sid_o <= SID_IDLE;
                        req_rdy_o <= grant_mask;
                        watchdog  <= '0;
                        // A peripheral that answers in the accept cycle completes the transaction here.
                        if (per_res_valid_i) begin
                            res_o       <= per_res_i;
                            res_valid_o <= grant_mask;
                            rr_ptr      <= next_ptr;
                            state       <= IDLE_S;
                        end else begin
                            state <= WAIT_RES_S;
                        end
                    end
                end
                WAIT_RES_S: begin
                    if (per_res_valid_i) begin
                        res_o       <= per_res_i;
                        res_valid_o <= grant_mask;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE_S;
                    end else if (watchdog == WD_W'(P_TIMEOUT - 1)) begin
                        // Abort still pulses res_valid so the requester is released.
                        timeout_err_o <= 1'b1;
                        res_o         <= '0;
                        res_valid_o   <= grant_mask;
                        rr_ptr        <= next_ptr;
                        state         <= IDLE_S;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end
endmodule

// File: tb/tb_syn_mulberry_bus_arbiter.sv
// Bench for syn_mulberry_bus_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_syn_mulberry_bus_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int SW  = 2;
    localparam int TMO = 1023;
    localparam int IW  = 2;
    localparam logic [SW-1:0] SID_IDLE = 2'd0;
    localparam logic [SW-1:0] SID_MUL  = 2'd1;
    localparam logic [SW-1:0] SID_DIV  = 2'd2;

    logic            clk_ir = 1'b0;
    logic            rst_ir = 1'b1;
    logic [N*SW-1:0] req_sid_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_rdy_o, res_valid_o;
    logic [DW-1:0]   res_o, per_data_o;
    logic [SW-1:0]   per_sid_o;
    logic            per_req_rdy_i = 1'b0, per_res_valid_i = 1'b0;
    logic [DW-1:0]   per_res_i = '0;
    logic            timeout_err_o;
    logic [IW-1:0]   grant_id_o;

    syn_mulberry_bus_arbiter #(.P_NUM_REQ(N), .P_DATA_W(DW), .P_SID_W(SW), .P_TIMEOUT(TMO)) dut (
        .clk_ir(clk_ir), .rst_ir(rst_ir), .req_sid_i(req_sid_i), .req_data_i(req_data_i),
        .req_rdy_o(req_rdy_o), .res_valid_o(res_valid_o), .res_o(res_o), .per_sid_o(per_sid_o),
        .per_data_o(per_data_o), .per_req_rdy_i(per_req_rdy_i), .per_res_valid_i(per_res_valid_i),
        .per_res_i(per_res_i), .timeout_err_o(timeout_err_o), .grant_id_o(grant_id_o)
    );

    always #5 clk_ir = ~clk_ir;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one transaction record plus the round-robin start point.
    bit            m_busy, m_acc, m_tmo;
    int            m_wait, m_rr, m_gid;
    logic [SW-1:0] m_sid;
    logic [DW-1:0] m_data, m_res;
    logic [N-1:0]  m_rdy, m_resv;

    // Stimulus state: requester plans and a scripted peripheral.
    logic [SW-1:0] sid_a [N];
    logic [DW-1:0] dat_a [N];
    logic [SW-1:0] plan_sid [N][4];
    int            plan_len [N];
    int            plan_pos [N];
    bit            outst, hang;
    int            pc, rdy_dly, res_dly;
    logic [DW-1:0] p_lat;
    int            order_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_tmo = 0; m_wait = 0; m_rr = 0; m_gid = 0;
        m_sid = SID_IDLE; m_data = '0; m_res = '0; m_rdy = '0; m_resv = '0;
    endtask

    task automatic model_finish(input logic [DW-1:0] v, input bit aborted);
        m_busy = 0;
        m_res = v;
        m_resv[m_gid] = 1'b1;
        m_rr = (m_gid + 1) % N;
        if (aborted) m_tmo = 1;
    endtask

    task automatic model_update();
        int pick;
        m_rdy = '0;
        m_resv = '0;
        if (!m_busy) begin
            pick = -1;
            for (int d = 0; d < N; d++)
                if (pick < 0 && sid_a[(m_rr + d) % N] != SID_IDLE) pick = (m_rr + d) % N;
            if (pick >= 0) begin
                m_busy = 1; m_acc = 0; m_gid = pick;
                m_sid = sid_a[pick]; m_data = dat_a[pick];
            end
        end else if (!m_acc) begin
            if (per_req_rdy_i) begin
                m_acc = 1; m_wait = 0; m_sid = SID_IDLE; m_rdy[m_gid] = 1'b1;
                if (per_res_valid_i) model_finish(per_res_i, 0);
            end
        end else if (per_res_valid_i) begin
            model_finish(per_res_i, 0);
        end else begin
            m_wait++;
            if (m_wait == TMO) model_finish('0, 1);
        end
    endtask

    task automatic compare_all();
        chk("per_sid", 64'(per_sid_o), 64'(m_sid));
        chk("per_data", 64'(per_data_o), 64'(m_data));
        chk("req_rdy", 64'(req_rdy_o), 64'(m_rdy));
        chk("res_valid", 64'(res_valid_o), 64'(m_resv));
        chk("res", 64'(res_o), 64'(m_res));
        chk("timeout_err", 64'(timeout_err_o), 64'(m_tmo));
        chk("grant_id", 64'(grant_id_o), 64'(m_gid));
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_sid_i[i*SW +: SW]  = sid_a[i];
            req_data_i[i*DW +: DW] = dat_a[i];
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            plan_len[i] = 0; plan_pos[i] = 0; sid_a[i] = SID_IDLE; dat_a[i] = '0;
        end
        outst = 0; hang = 0; pc = 0; rdy_dly = 0; res_dly = 0;
        per_req_rdy_i = 0; per_res_valid_i = 0; per_res_i = '0;
        order_q.delete();
        apply_inputs();
    endtask

    task automatic step();
        model_update();
        @(posedge clk_ir);
        @(negedge clk_ir);
        compare_all();
    endtask

    task automatic reset_dut();
        rst_ir = 1'b1;
        clear_stim();
        model_reset();
        #1 compare_all();
        @(posedge clk_ir);
        @(negedge clk_ir);
        rst_ir = 1'b0;
    endtask

    // Requesters present the head of their plan; the peripheral accepts after rdy_dly, answers after res_dly.
    task automatic drive_auto();
        for (int i = 0; i < N; i++) begin
            if (res_valid_o[i]) plan_pos[i]++;
            sid_a[i] = (plan_pos[i] < plan_len[i]) ? plan_sid[i][plan_pos[i]] : SID_IDLE;
            dat_a[i] = {16'(3 + i + plan_pos[i]), 16'd5};
        end
        if (res_valid_o != '0) outst = 0;
        per_req_rdy_i = 0; per_res_valid_i = 0; per_res_i = '0;
        if (!outst && per_sid_o != SID_IDLE) begin
            if (pc >= rdy_dly) begin
                per_req_rdy_i = 1; outst = 1; pc = 0; p_lat = per_data_o;
                order_q.push_back(int'(grant_id_o) * 4 + int'(per_sid_o));
            end else pc++;
        end
        if (outst && !hang) begin
            if (pc >= res_dly) begin
                per_res_valid_i = 1; per_res_i = p_lat[31:16] * p_lat[15:0]; outst = 0; pc = 0;
            end else pc++;
        end
        apply_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp2 [5] = '{0, 1, 2, 3, 0};
        int exp3 [3] = '{5, 10, 6};
        bit saw_rdy, saw_res, done;
        int cnt;

        @(negedge clk_ir);
        // Single request: MUL 3*5 on requester 0.
        reset_dut();
        plan_sid[0][0] = SID_MUL; plan_len[0] = 1; rdy_dly = 2; res_dly = 3;
        drive_auto(); step();
        chk("t1_sid", 64'(per_sid_o), 64'(SID_MUL));
        chk("t1_data", 64'(per_data_o), 64'h0003_0005);
        chk("t1_gid", 64'(grant_id_o), 64'd0);
        saw_rdy = 0; saw_res = 0;
        for (int k = 0; k < 20; k++) begin
            drive_auto(); step();
            if (req_rdy_o != '0) begin chk("t1_rdy", 64'(req_rdy_o), 64'h1); saw_rdy = 1; end
            if (res_valid_o != '0) begin
                chk("t1_resv", 64'(res_valid_o), 64'h1);
                chk("t1_res", 64'(res_o), 64'hF);
                saw_res = 1;
            end
        end
        chk("t1_seen", 64'({saw_rdy, saw_res}), 64'h3);

        // All four requesting: strict round-robin order.
        reset_dut();
        for (int i = 0; i < N; i++) begin plan_sid[i][0] = SID_MUL; plan_sid[i][1] = SID_MUL; plan_len[i] = 1; end
        plan_len[0] = 2; rdy_dly = 0; res_dly = 1;
        for (int k = 0; k < 40; k++) begin drive_auto(); step(); end
        chk("t2_count", 64'(order_q.size()), 64'd5);
        for (int k = 0; k < 5 && k < order_q.size(); k++) chk("t2_order", 64'(order_q[k] / 4), 64'(exp2[k]));

        // Chained MUL->DIV on requester 1 with requester 2 pending.
        reset_dut();
        plan_sid[1][0] = SID_MUL; plan_sid[1][1] = SID_DIV; plan_len[1] = 2;
        plan_sid[2][0] = SID_DIV; plan_len[2] = 1; rdy_dly = 0; res_dly = 2;
        for (int k = 0; k < 40; k++) begin drive_auto(); step(); end
        chk("t3_count", 64'(order_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < order_q.size(); k++) chk("t3_order", 64'(order_q[k]), 64'(exp3[k]));

        // Accept and result in the same cycle.
        reset_dut();
        plan_sid[3][0] = SID_MUL; plan_len[3] = 1; rdy_dly = 1; res_dly = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive_auto(); step();
            if (req_rdy_o != '0) begin
                chk("t5_rdy", 64'(req_rdy_o), 64'h8);
                chk("t5_resv", 64'(res_valid_o), 64'h8);
                chk("t5_res", 64'(res_o), 64'h1E);
                done = 1;
            end
        end
        chk("t5_seen", 64'(done), 64'd1);
        plan_sid[0][0] = SID_DIV; plan_len[0] = 1;
        drive_auto(); step();
        chk("t5_regrant_sid", 64'(per_sid_o), 64'(SID_DIV));
        chk("t5_regrant_gid", 64'(grant_id_o), 64'd0);
        for (int k = 0; k < 10; k++) begin drive_auto(); step(); end

        // Hung peripheral: watchdog abort after TMO wait cycles.
        reset_dut();
        plan_sid[0][0] = SID_MUL; plan_len[0] = 1;
        plan_sid[2][0] = SID_DIV; plan_len[2] = 1; hang = 1;
        cnt = -1; done = 0;
        for (int k = 0; k < 1200 && !done; k++) begin
            drive_auto(); step();
            if (cnt >= 0) cnt++;
            if (req_rdy_o != '0) cnt = 0;
            if (res_valid_o != '0) begin
                chk("t4_resv", 64'(res_valid_o), 64'h1);
                chk("t4_res", 64'(res_o), 64'h0);
                chk("t4_tmo", 64'(timeout_err_o), 64'h1);
                chk("t4_wait_cycles", 64'(cnt), 64'(TMO));
                done = 1;
            end
        end
        chk("t4_fired", 64'(done), 64'd1);
        hang = 0;
        drive_auto(); step();
        chk("t4_next_gid", 64'(grant_id_o), 64'd2);
        chk("t4_next_sid", 64'(per_sid_o), 64'(SID_DIV));
        for (int k = 0; k < 10; k++) begin drive_auto(); step(); end
        chk("t4_sticky", 64'(timeout_err_o), 64'h1);

        // Reset in the middle of a wait; a late result must be ignored.
        plan_sid[1][0] = SID_MUL; plan_len[1] = 1; plan_pos[1] = 0; hang = 1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive_auto(); step();
            if (req_rdy_o != '0) done = 1;
        end
        chk("t6_in_wait", 64'(done), 64'd1);
        for (int k = 0; k < 5; k++) begin drive_auto(); step(); end
        rst_ir = 1'b1;
        #1;
        chk("t6_rst_sid", 64'(per_sid_o), 64'(SID_IDLE));
        chk("t6_rst_data", 64'(per_data_o), 64'h0);
        chk("t6_rst_pulses", 64'({req_rdy_o, res_valid_o}), 64'h0);
        chk("t6_rst_res", 64'(res_o), 64'h0);
        chk("t6_rst_tmo", 64'(timeout_err_o), 64'h0);
        chk("t6_rst_gid", 64'(grant_id_o), 64'h0);
        model_reset();
        clear_stim();
        @(posedge clk_ir);
        @(negedge clk_ir);
        rst_ir = 1'b0;
        per_res_valid_i = 1; per_res_i = 32'h1234;
        step();
        chk("t6_late_resv", 64'(res_valid_o), 64'h0);
        chk("t6_late_res", 64'(res_o), 64'h0);

        // Random traffic, including spurious handshakes and mid-transaction sid changes.
        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                sid_a[i] = ($urandom_range(0, 1) == 0) ? SID_IDLE : SW'($urandom_range(1, 3));
                dat_a[i] = $urandom;
            end
            per_req_rdy_i   = ($urandom_range(0, 2) == 0);
            per_res_valid_i = ($urandom_range(0, 3) == 0);
            per_res_i       = $urandom;
            apply_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
